// File: rtl/systolic_row_feeder.sv
// West-edge operand feeder for the systolic array: skews A-operand lanes, then drains zeros.
// Optional accepted-beat counter output k_count is enabled by defining FEEDER_KCOUNT_EN.
module systolic_row_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] a_lane,
    output logic                       arr_en,
    output logic                       arr_clr,
    output logic                       busy,
`ifdef FEEDER_KCOUNT_EN
    output logic                       done,
    output logic [15:0]                k_count
`else
    output logic                       done
`endif
);

    localparam int unsigned DRAIN_LEN = ROWS + COLS - 2;
    localparam int unsigned CNT_W     = $clog2(ROWS + COLS);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             advance;
    logic             arr_en_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StClear;
            StClear: state_d = StFeed;
            StFeed: begin
                if (in_valid && in_last) begin
                    if (DRAIN_LEN == 0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDrain;
                        cnt_d   = CNT_W'(DRAIN_LEN - 1);
                    end
                end
            end
            StDrain: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StFeed);
        arr_clr  = (state_q == StClear);
        busy     = (state_q != StIdle);
        advance  = ((state_q == StFeed) && in_valid) || (state_q == StDrain);
    end

    // Enable lines up with the cycle the shifted lane values become visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            arr_en_q <= advance;
            done_q   <= (state_q == StDone);
        end
    end

    assign arr_en = arr_en_q;
    assign done   = done_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr_q [r+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) sr_q[i] <= '0;
            end else if (state_q == StClear) begin
                for (int i = 0; i <= r; i++) sr_q[i] <= '0;
            end else if (advance) begin
                sr_q[0] <= (state_q == StFeed) ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int i = 1; i <= r; i++) sr_q[i] <= sr_q[i-1];
            end
        end

        assign a_lane[r*DATA_WIDTH +: DATA_WIDTH] = sr_q[r];
    end

`ifdef FEEDER_KCOUNT_EN
    logic [15:0] kc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_q <= '0;
        end else if (state_q == StClear) begin
            kc_q <= '0;
        end else if ((state_q == StFeed) && in_valid && (kc_q != 16'hFFFF)) begin
            kc_q <= kc_q + 16'd1;
        end
    end

    assign k_count = kc_q;
`endif

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: random and directed jobs checked against a queue-based beat
// history model; a second 1x1 instance covers the zero-drain case.
module tb_systolic_row_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam int          D  = R + C - 2;
    localparam int unsigned W  = R * DW;

    localparam int PIdle = 0, PClear = 1, PFeed = 2, PDrain = 3, PDone = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, in_valid, in_last;
    logic [W-1:0]  in_data;
    logic          in_ready, arr_en, arr_clr, busy, done;
    logic [W-1:0]  a_lane;
    logic [15:0]   k_count;

    logic          s_start, s_in_valid, s_in_last;
    logic [DW-1:0] s_in_data;
    logic          s_in_ready, s_arr_en, s_arr_clr, s_busy, s_done;
    logic [DW-1:0] s_a_lane;
    logic [15:0]   s_k_count;

    always #5 clk = ~clk;

    systolic_row_feeder #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .a_lane   (a_lane),
        .arr_en   (arr_en),
        .arr_clr  (arr_clr),
        .busy     (busy),
`ifdef FEEDER_KCOUNT_EN
        .done     (done),
        .k_count  (k_count)
`else
        .done     (done)
`endif
    );

    systolic_row_feeder #(.DATA_WIDTH(DW), .ROWS(1), .COLS(1)) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s_start),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  (s_in_data),
        .in_last  (s_in_last),
        .a_lane   (s_a_lane),
        .arr_en   (s_arr_en),
        .arr_clr  (s_arr_clr),
        .busy     (s_busy),
`ifdef FEEDER_KCOUNT_EN
        .done     (s_done),
        .k_count  (s_k_count)
`else
        .done     (s_done)
`endif
    );

`ifndef FEEDER_KCOUNT_EN
    assign k_count   = '0;
    assign s_k_count = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase of the job plus the history of every advance (beats then zeros).
    int           phase = PIdle;
    int           left  = 0;
    int           m_k   = 0;
    bit           m_en  = 1'b0;
    bit           m_done = 1'b0;
    logic [W-1:0] hist[$];

    int en_cnt, clr_cnt;
    bit dir_lane3 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_lanes();
        logic [W-1:0] v;
        int idx;
        v = '0;
        for (int r = 0; r < R; r++) begin
            idx = hist.size() - 1 - r;
            if (idx >= 0) v[r*DW +: DW] = hist[idx][r*DW +: DW];
        end
        return v;
    endfunction

    // One clock: step the model on the current inputs, clock, compare every output.
    task automatic tick();
        int prev;
        bit adv;
        prev = phase;
        adv  = 1'b0;
        case (phase)
            PIdle:  if (start) phase = PClear;
            PClear: begin
                hist.delete();
                m_k   = 0;
                phase = PFeed;
            end
            PFeed: begin
                if (in_valid) begin
                    hist.push_back(in_data);
                    adv = 1'b1;
                    if (m_k < 65535) m_k++;
                    if (in_last) begin
                        if (D == 0) phase = PDone;
                        else begin
                            phase = PDrain;
                            left  = D;
                        end
                    end
                end
            end
            PDrain: begin
                hist.push_back('0);
                adv = 1'b1;
                left--;
                if (left == 0) phase = PDone;
            end
            default: phase = PIdle;
        endcase
        m_en   = adv;
        m_done = (prev == PDone);
        @(posedge clk);
        #1;
        check_eq("in_ready", in_ready, phase == PFeed);
        check_eq("arr_clr", arr_clr, phase == PClear);
        check_eq("busy", busy, phase != PIdle);
        check_eq("arr_en", arr_en, m_en);
        check_eq("done", done, m_done);
        check_eq("a_lane", a_lane, exp_lanes());
`ifdef FEEDER_KCOUNT_EN
        check_eq("k_count", k_count, m_k);
`endif
        if (arr_clr) clr_cnt++;
        if (arr_en) begin
            en_cnt++;
            if (dir_lane3) begin
                if (en_cnt >= 4 && en_cnt <= 6) check_eq("lane3_dir", a_lane[W-1 -: DW], 4 * (en_cnt - 3));
                else                            check_eq("lane3_dir", a_lane[W-1 -: DW], 0);
            end
        end
    endtask

    task automatic begin_job();
        en_cnt  = 0;
        clr_cnt = 0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
    endtask

    task automatic feed_beats(input int k, input int gap, input bit rnd, input bit poke);
        int nb;
        for (int b = 0; b < k; b++) begin
            nb = (b == 1) ? gap : 0;
            if (rnd && b > 0 && $urandom_range(0, 3) == 0) nb = $urandom_range(1, 2);
            for (int g = 0; g < nb; g++) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_data  = {$urandom(), $urandom()};
                tick();
            end
            in_valid = 1'b1;
            in_last  = (b == k - 1);
            if (rnd) in_data = {$urandom(), $urandom()};
            else for (int r = 0; r < R; r++) in_data[r*DW +: DW] = DW'(b * R + r + 1);
            if (poke && b == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_job(input int k, input int gap, input bit rnd, input bit poke);
        begin_job();
        feed_beats(k, gap, rnd, poke);
        for (int guard = 0; guard < 200 && !done; guard++) begin
            if (poke && phase == PDone) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_eq("done_seen", done, 1);
        check_eq("en_count", en_cnt, k + D);
        check_eq("clr_count", clr_cnt, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        s_in_data  = '0;
        #12;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_a_lane", a_lane, 0);
        check_eq("rst_arr_en", arr_en, 0);
        check_eq("rst_arr_clr", arr_clr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back, then the same job with a two-cycle bubble, then start pokes.
        dir_lane3 = 1'b1;
        run_job(3, 0, 1'b0, 1'b0);
        run_job(3, 2, 1'b0, 1'b0);
        dir_lane3 = 1'b0;
        run_job(3, 0, 1'b0, 1'b1);

        // Inputs other than start are ignored while idle.
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom(), $urandom()};
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Reset asserted while drain advance 3 is in progress.
        begin_job();
        feed_beats(2, 0, 1'b1, 1'b0);
        for (int guard = 0; guard < 50 && !(phase == PDrain && left == D - 2); guard++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_in_ready", in_ready, 0);
        check_eq("mrst_a_lane", a_lane, 0);
        check_eq("mrst_arr_en", arr_en, 0);
        check_eq("mrst_arr_clr", arr_clr, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_done", done, 0);
        phase  = PIdle;
        m_k    = 0;
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_job(4, 1, 1'b1, 1'b0);

        // Degenerate 1x1 instance, K=1: no drain at all.
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        check_eq("s_clr", s_arr_clr, 1);
        check_eq("s_busy", s_busy, 1);
        @(posedge clk); #1;
        check_eq("s_ready", s_in_ready, 1);
        s_in_valid = 1'b1;
        s_in_last  = 1'b1;
        s_in_data  = 16'hABCD;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_last  = 1'b0;
        check_eq("s_en", s_arr_en, 1);
        check_eq("s_lane", s_a_lane, 16'hABCD);
        check_eq("s_ready_after", s_in_ready, 0);
        check_eq("s_done_early", s_done, 0);
        @(posedge clk); #1;
        check_eq("s_en_off", s_arr_en, 0);
        check_eq("s_done", s_done, 1);
        @(posedge clk); #1;
        check_eq("s_done_off", s_done, 0);
        check_eq("s_idle", s_busy, 0);

        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(1, 7)), int'($urandom_range(0, 2)), 1'b1,
                    1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
        end

        run_job(5, 0, 1'b1, 1'b0);
`ifdef FEEDER_KCOUNT_EN
        tick();
        check_eq("kcount_hold", k_count, 5);
        begin_job();
        check_eq("kcount_clear", k_count, 0);
        feed_beats(1, 0, 1'b1, 1'b0);
        for (int guard = 0; guard < 50 && !done; guard++) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
